// File: rtl/imem_loader_if.sv
// Stream-in / imem-write bundle for the boot loader.
// slave = loader side, master = stream source and imem/top-level side.
interface imem_loader_if #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [XLEN-1:0]       wdata;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [ADDR_WIDTH:0]   words_written;

    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, we, waddr, wdata, busy, done, err, words_written
    );

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, we, waddr, wdata, busy, done, err, words_written
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: byte stream (N lo, N hi, N*4 LE bytes) to imem words.
// Optional LOADER_CHECKSUM_EN adds an XOR trailer byte checked in CSUM.
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// HDR0   | expecting N[7:0]
// HDR1   | expecting N[15:8]
// DATA   | receiving payload bytes, writing one word per 4 bytes
// CSUM   | expecting XOR trailer (LOADER_CHECKSUM_EN only)
// DONE   | load finished OK, sticky until start
// ERROR  | load rejected, sticky until start
module imem_loader #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    imem_loader_if.slave  bus
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("imem_loader: only XLEN=32 is supported");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 16) begin : g_bad_aw
        $error("imem_loader: ADDR_WIDTH must be 1..16");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
`ifdef LOADER_CHECKSUM_EN
        , S_CSUM = 3'd6
`endif
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    localparam logic [16:0]           DEPTH17 = 17'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = 1;
    localparam logic [ADDR_WIDTH:0]   ONE_W   = 1;

    state_t                state, state_n;
    logic                  busy_c, done_c, err_c;
    logic                  accept;
    logic                  start_ok;
    logic [7:0]            n_lo;
    logic [15:0]           n_hdr;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic [1:0]            byte_cnt;
    logic [23:0]           asm_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [XLEN-1:0]       wdata_q;
    logic [ADDR_WIDTH:0]   words_q;
    logic                  last_byte;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    assign accept    = bus.rx_valid && busy_c;
    assign n_hdr     = {bus.rx_data, n_lo};
    assign start_ok  = bus.start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign last_byte = (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (bus.start) state_n = S_HDR0;
            end
            S_HDR0: begin
                if (accept) state_n = S_HDR1;
            end
            S_HDR1: begin
                if (accept) begin
                    if ({1'b0, n_hdr} > DEPTH17) begin
                        state_n = S_ERROR;
                    end else if (n_hdr == 16'd0) begin
                        state_n = S_TAIL;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && last_byte && word_cnt == last_idx) state_n = S_TAIL;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) state_n = (bus.rx_data == csum_q) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE, S_ERROR: begin
                if (bus.start) state_n = S_HDR0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        err_c  = 1'b0;
        case (state)
            S_HDR0, S_HDR1, S_DATA: busy_c = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:                 busy_c = 1'b1;
`endif
            S_DONE:                 done_c = 1'b1;
            S_ERROR:                err_c  = 1'b1;
            default: ;
        endcase
    end

    // Bytes 0..2 shift in from the top so byte 0 ends up in the low lane.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_lo     <= '0;
            last_idx <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            asm_q    <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            words_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            if (start_ok) begin
                word_cnt <= '0;
                byte_cnt <= '0;
                asm_q    <= '0;
                words_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum_q   <= '0;
`endif
            end else if (accept) begin
                case (state)
                    S_HDR0: n_lo <= bus.rx_data;
                    S_HDR1: last_idx <= ADDR_WIDTH'(n_hdr - 16'd1);
                    S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ bus.rx_data;
`endif
                        if (last_byte) begin
                            we_q     <= 1'b1;
                            waddr_q  <= word_cnt;
                            wdata_q  <= XLEN'({bus.rx_data, asm_q});
                            words_q  <= words_q + ONE_W;
                            byte_cnt <= 2'd0;
                            // Hold at N-1 so the address never wraps.
                            if (word_cnt != last_idx) word_cnt <= word_cnt + ONE_A;
                        end else begin
                            asm_q    <= {bus.rx_data, asm_q[23:8]};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rx_ready      = busy_c;
    assign bus.busy          = busy_c;
    assign bus.done          = done_c;
    assign bus.err           = err_c;
    assign bus.we            = we_q;
    assign bus.waddr         = waddr_q;
    assign bus.wdata         = wdata_q;
    assign bus.words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized loads
// compared against a byte-stream reference model. Define LOADER_CHECKSUM_EN to match the RTL build.
module tb_imem_loader;

    localparam int XLEN  = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 2**AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    imem_loader_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) ifc ();

    imem_loader #(.XLEN(XLEN), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW+XLEN-1:0] wq[$];
    logic [7:0]         pay[$];

    always @(negedge clk) begin
        if (ifc.we === 1'b1) wq.push_back({ifc.waddr, ifc.wdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
    endtask

    // Present one byte, optionally after random idle cycles; returns 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int idle  = 0;
        int waitc = 0;
        while (gap_pct > 0 && idle < 8 && $urandom_range(99) < gap_pct) begin
            ifc.rx_valid = 1'b0;
            ifc.rx_data  = 8'($urandom);
            tick();
            idle++;
        end
        ifc.rx_valid = 1'b1;
        ifc.rx_data  = b;
        while (ifc.rx_ready !== 1'b1 && waitc < 20) begin
            tick();
            waitc++;
        end
        if (ifc.rx_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL send_byte_timeout rx_ready=%b required 1", ifc.rx_ready);
            ifc.rx_valid = 1'b0;
        end else begin
            tick();
        end
    endtask

    function automatic logic [XLEN-1:0] model_word(input int i);
        return {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
    endfunction

    function automatic logic [7:0] model_xor();
        logic [7:0] x = 8'h00;
        foreach (pay[i]) x ^= pay[i];
        return x;
    endfunction

    task automatic load_test2_payload();
        pay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    endtask

    // Full load of pay[] with header n; the model predicts outcome and every write.
    task automatic run_load(input string tag, input int n, input int gap_pct, input bit bad_csum);
        bit exp_err;
        int exp_ww;
        pulse_start();
        wq.delete();
        send_byte(8'(n), gap_pct);
        send_byte(8'(n >> 8), gap_pct);
        if (n <= DEPTH) begin
            for (int i = 0; i < 4*n; i++) send_byte(pay[i], gap_pct);
`ifdef LOADER_CHECKSUM_EN
            send_byte(model_xor() ^ {7'd0, bad_csum}, gap_pct);
`endif
        end
        ifc.rx_valid = 1'b0;
        tick();
        tick();
`ifdef LOADER_CHECKSUM_EN
        exp_err = (n > DEPTH) || bad_csum;
`else
        exp_err = (n > DEPTH);
`endif
        exp_ww = (n > DEPTH) ? 0 : n;
        n_checks++;
        if ({ifc.done, ifc.err, ifc.busy} !== {!exp_err, exp_err, 1'b0})
            $display("FAIL %s status done/err/busy=%b%b%b required %b%b0", tag,
                     ifc.done, ifc.err, ifc.busy, !exp_err, exp_err);
        else n_pass++;
        n_checks++;
        if (ifc.words_written !== (AW+1)'(exp_ww))
            $display("FAIL %s words_written=%0d required %0d", tag, ifc.words_written, exp_ww);
        else n_pass++;
        n_checks++;
        if (wq.size() !== exp_ww)
            $display("FAIL %s write_count=%0d required %0d", tag, wq.size(), exp_ww);
        else n_pass++;
        for (int i = 0; i < exp_ww && i < wq.size(); i++) begin
            n_checks++;
            if (wq[i] !== {AW'(i), model_word(i)})
                $display("FAIL %s write[%0d] addr/data=%h required %h", tag, i, wq[i],
                         {AW'(i), model_word(i)});
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        ifc.start = 1'b0; ifc.rx_valid = 1'b0; ifc.rx_data = 8'h00;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({ifc.rx_ready, ifc.we, ifc.busy, ifc.done, ifc.err, ifc.words_written, ifc.waddr, ifc.wdata} !== '0)
            $display("FAIL reset_outputs rdy/we/busy/done/err=%b%b%b%b%b ww=%0d waddr=%h wdata=%h required all 0",
                     ifc.rx_ready, ifc.we, ifc.busy, ifc.done, ifc.err, ifc.words_written, ifc.waddr, ifc.wdata);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [7:0] s[10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        pulse_start();
        wq.delete();
        for (int i = 0; i < 10; i++) begin
            send_byte(s[i], 0);
            if (i == 5) begin
                n_checks++;
                if ({ifc.we, ifc.waddr, ifc.wdata, ifc.done} !== {1'b1, 8'd0, 32'h00000013, 1'b0})
                    $display("FAIL basic_word0 we=%b waddr=%h wdata=%h done=%b required 1 00 00000013 0",
                             ifc.we, ifc.waddr, ifc.wdata, ifc.done);
                else n_pass++;
            end
        end
        ifc.rx_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        n_checks++;
        if ({ifc.we, ifc.waddr, ifc.wdata, ifc.done, ifc.busy} !== {1'b1, 8'd1, 32'h00100093, 1'b0, 1'b1})
            $display("FAIL basic_word1 we=%b waddr=%h wdata=%h done=%b busy=%b required 1 01 00100093 0 1",
                     ifc.we, ifc.waddr, ifc.wdata, ifc.done, ifc.busy);
        else n_pass++;
        send_byte(8'h90, 0);
        ifc.rx_valid = 1'b0;
        n_checks++;
        if ({ifc.done, ifc.busy} !== 2'b10)
            $display("FAIL basic_csum_done done/busy=%b%b required 10", ifc.done, ifc.busy);
        else n_pass++;
`else
        n_checks++;
        if ({ifc.we, ifc.waddr, ifc.wdata, ifc.done, ifc.busy} !== {1'b1, 8'd1, 32'h00100093, 1'b1, 1'b0})
            $display("FAIL basic_word1 we=%b waddr=%h wdata=%h done=%b busy=%b required 1 01 00100093 1 0",
                     ifc.we, ifc.waddr, ifc.wdata, ifc.done, ifc.busy);
        else n_pass++;
`endif
        tick();
        n_checks++;
        if ({ifc.we, ifc.waddr, ifc.wdata, ifc.words_written} !== {1'b0, 8'd1, 32'h00100093, 9'd2})
            $display("FAIL basic_hold we=%b waddr=%h wdata=%h ww=%0d required 0 01 00100093 2",
                     ifc.we, ifc.waddr, ifc.wdata, ifc.words_written);
        else n_pass++;
        n_checks++;
        if (wq.size() !== 2)
            $display("FAIL basic_write_count=%0d required 2", wq.size());
        else n_pass++;
    endtask

    task automatic test_gaps();
        int ready_low = 0;
        load_test2_payload();
        pulse_start();
        wq.delete();
        n_checks++;
        if ({ifc.busy, ifc.done, ifc.words_written} !== {1'b1, 1'b0, 9'd0})
            $display("FAIL gaps_start_clear busy=%b done=%b ww=%0d required 1 0 0",
                     ifc.busy, ifc.done, ifc.words_written);
        else n_pass++;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 8; i++) begin
            ifc.rx_valid = 1'b0;
            ifc.rx_data  = 8'($urandom);
            ifc.start    = (i == 3);
            tick();
            ifc.start = 1'b0;
            if (ifc.rx_ready !== 1'b1) ready_low++;
            send_byte(pay[i], 0);
        end
`ifdef LOADER_CHECKSUM_EN
        ifc.rx_valid = 1'b0;
        tick();
        send_byte(8'h90, 0);
`endif
        ifc.rx_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (ready_low !== 0)
            $display("FAIL gaps_ready_in_data low_cycles=%0d required 0", ready_low);
        else n_pass++;
        n_checks++;
        if (wq.size() !== 2)
            $display("FAIL gaps_write_count=%0d required 2", wq.size());
        else n_pass++;
        for (int i = 0; i < 2 && i < wq.size(); i++) begin
            n_checks++;
            if (wq[i] !== {AW'(i), model_word(i)})
                $display("FAIL gaps_write[%0d]=%h required %h", i, wq[i], {AW'(i), model_word(i)});
            else n_pass++;
        end
        n_checks++;
        if ({ifc.done, ifc.words_written} !== {1'b1, 9'd2})
            $display("FAIL gaps_done done=%b ww=%0d required 1 2", ifc.done, ifc.words_written);
        else n_pass++;
    endtask

    task automatic test_oversize();
        pulse_start();
        wq.delete();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        ifc.rx_valid = 1'b0;
        n_checks++;
        if ({ifc.err, ifc.done, ifc.busy, ifc.rx_ready} !== 4'b1000)
            $display("FAIL oversize_err err/done/busy/rdy=%b%b%b%b required 1000",
                     ifc.err, ifc.done, ifc.busy, ifc.rx_ready);
        else n_pass++;
        ifc.rx_valid = 1'b1;
        ifc.rx_data  = 8'h55;
        tick();
        tick();
        ifc.rx_valid = 1'b0;
        n_checks++;
        if ({wq.size(), ifc.words_written} !== {32'd0, 9'd0})
            $display("FAIL oversize_no_write writes=%0d ww=%0d required 0 0", wq.size(), ifc.words_written);
        else n_pass++;
        pulse_start();
        n_checks++;
        if ({ifc.err, ifc.busy} !== 2'b01)
            $display("FAIL oversize_restart err/busy=%b%b required 01", ifc.err, ifc.busy);
        else n_pass++;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        ifc.rx_valid = 1'b0;
        n_checks++;
        if (ifc.done !== 1'b1)
            $display("FAIL oversize_then_empty done=%b required 1", ifc.done);
        else n_pass++;
    endtask

    task automatic test_empty();
        pulse_start();
        wq.delete();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        ifc.rx_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        n_checks++;
        if ({ifc.done, ifc.busy} !== 2'b01)
            $display("FAIL empty_csum_wait done/busy=%b%b required 01", ifc.done, ifc.busy);
        else n_pass++;
        send_byte(8'h00, 0);
        ifc.rx_valid = 1'b0;
`endif
        n_checks++;
        if ({ifc.done, ifc.err, ifc.we} !== 3'b100)
            $display("FAIL empty_done done/err/we=%b%b%b required 100", ifc.done, ifc.err, ifc.we);
        else n_pass++;
        tick();
        n_checks++;
        if ({wq.size(), ifc.words_written} !== {32'd0, 9'd0})
            $display("FAIL empty_no_write writes=%0d ww=%0d required 0 0", wq.size(), ifc.words_written);
        else n_pass++;
    endtask

    task automatic test_reset_midload();
        logic [7:0] s[6] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(s[i], 0);
        ifc.rx_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({ifc.rx_ready, ifc.we, ifc.busy, ifc.done, ifc.err, ifc.words_written, ifc.waddr, ifc.wdata} !== '0)
            $display("FAIL midload_reset rdy/we/busy/done/err=%b%b%b%b%b ww=%0d waddr=%h wdata=%h required all 0",
                     ifc.rx_ready, ifc.we, ifc.busy, ifc.done, ifc.err, ifc.words_written, ifc.waddr, ifc.wdata);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        load_test2_payload();
        run_load("midload_reload", 2, 0, 1'b0);
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        load_test2_payload();
        run_load("csum_good", 2, 0, 1'b0);
        run_load("csum_bad", 2, 0, 1'b1);
    endtask
`endif

    task automatic test_full_depth();
        pay.delete();
        for (int i = 0; i < 4*DEPTH; i++) pay.push_back(8'($urandom));
        run_load("full_depth", DEPTH, 0, 1'b0);
        n_checks++;
        if (ifc.waddr !== AW'(DEPTH-1))
            $display("FAIL full_depth_last_waddr=%0d required %0d", ifc.waddr, DEPTH-1);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int n;
            int gap;
            bit bad;
            if ($urandom_range(7) == 0) n = DEPTH + 1 + int'($urandom_range(300));
            else n = int'($urandom_range(12));
            gap = int'($urandom_range(70));
            bad = ($urandom_range(3) == 0);
`ifndef LOADER_CHECKSUM_EN
            bad = 1'b0;
`endif
            pay.delete();
            for (int i = 0; i < 4*n && n <= DEPTH; i++) pay.push_back(8'($urandom));
            run_load($sformatf("random%0d_n%0d", it, n), n, gap, bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_oversize();
        test_empty();
        test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_full_depth();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
